instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 184 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded operation requests (team op numbering 0..36)
// into RV32I machine words behind a one-deep valid/ready output register,
// and tracks the byte address of each emitted word.
// Optional feature: define ENC_ILLEGAL_CHECK_EN to range-check immediates and
// drop illegal requests; without it immediates are truncated to their field
// and an unknown op is replaced by a NOP.
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;       // instr[30]: selects SUB/SRA/SRAI
  logic [31:0] word;
  logic        illegal;
  logic        accept;
  logic        out_fire;
  logic        emit;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Decode the op number into instruction format, major opcode and funct3.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    fmt    = FMT_BAD;
    opcode = OPC_OP_IMM;
    funct3 = 3'b000;
    alt    = 1'b0;
    case (op)
      6'd0:  begin fmt = FMT_I;  funct3 = 3'b000; end
      6'd1:  begin fmt = FMT_I;  funct3 = 3'b010; end
      6'd2:  begin fmt = FMT_I;  funct3 = 3'b011; end
      6'd3:  begin fmt = FMT_I;  funct3 = 3'b100; end
      6'd4:  begin fmt = FMT_I;  funct3 = 3'b110; end
      6'd5:  begin fmt = FMT_I;  funct3 = 3'b111; end
      6'd6:  begin fmt = FMT_SH; funct3 = 3'b001; end
      6'd7:  begin fmt = FMT_SH; funct3 = 3'b101; end
      6'd8:  begin fmt = FMT_SH; funct3 = 3'b101; alt = 1'b1; end
      6'd9:  begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b000; end
      6'd10: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b000; alt = 1'b1; end
      6'd11: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b001; end
      6'd12: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b010; end
      6'd13: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b011; end
      6'd14: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b100; end
      6'd15: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b101; end
      6'd16: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b101; alt = 1'b1; end
      6'd17: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b110; end
      6'd18: begin fmt = FMT_R;  opcode = OPC_OP; funct3 = 3'b111; end
      6'd19: begin fmt = FMT_I;  opcode = OPC_LOAD; funct3 = 3'b000; end
      6'd20: begin fmt = FMT_I;  opcode = OPC_LOAD; funct3 = 3'b001; end
      6'd21: begin fmt = FMT_I;  opcode = OPC_LOAD; funct3 = 3'b010; end
      6'd22: begin fmt = FMT_I;  opcode = OPC_LOAD; funct3 = 3'b100; end
      6'd23: begin fmt = FMT_I;  opcode = OPC_LOAD; funct3 = 3'b101; end
      6'd24: begin fmt = FMT_S;  opcode = OPC_STORE; funct3 = 3'b000; end
      6'd25: begin fmt = FMT_S;  opcode = OPC_STORE; funct3 = 3'b001; end
      6'd26: begin fmt = FMT_S;  opcode = OPC_STORE; funct3 = 3'b010; end
      6'd27: begin fmt = FMT_U;  opcode = OPC_LUI; end
      6'd28: begin fmt = FMT_U;  opcode = OPC_AUIPC; end
      6'd29: begin fmt = FMT_J;  opcode = OPC_JAL; end
      6'd30: begin fmt = FMT_I;  opcode = OPC_JALR; funct3 = 3'b000; end
      6'd31: begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'b000; end
      6'd32: begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'b001; end
      6'd33: begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'b100; end
      6'd34: begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'b101; end
      6'd35: begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'b110; end
      6'd36: begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'b111; end
      default: fmt = FMT_BAD;
    endcase
  end

  // Scatter register indices and immediate bits into the RV32I field layout;
  // unused register fields are left at zero, unknown ops become a NOP.
  always_comb begin
    word = NOP_WORD;
    case (fmt)
      FMT_R:   word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_SH:  word = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = NOP_WORD;
    endcase
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  // A value fits a signed N-bit field when all bits above N-1 repeat the sign.
  logic fits_12;
  logic fits_13;
  logic fits_21;
  assign fits_12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits_13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits_21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  // Flag unknown ops and immediates the target field cannot represent.
  always_comb begin
    case (fmt)
      FMT_I, FMT_S: illegal = !fits_12;
      FMT_SH:       illegal = (imm[31:5] != '0);
      FMT_B:        illegal = imm[0] || !fits_13;
      FMT_J:        illegal = imm[0] || !fits_21;
      FMT_U:        illegal = (imm[11:0] != '0);
      FMT_BAD:      illegal = 1'b1;
      default:      illegal = 1'b0;
    endcase
  end

  // Illegal requests are consumed but never reach the output.
  assign emit = accept && !illegal;
`else
  // Only an unknown op is illegal; it is still emitted, as a NOP.
  assign illegal = (fmt == FMT_BAD);
  assign emit    = accept;
`endif

  // Output register: load on acceptance, empty after the consumer takes it.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr     <= '0;
      err       <= 1'b0;
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        instr     <= word;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (accept && illegal) begin
        err <= 1'b1;
      end
    end
  end

  // Address counter: advances one word per output handshake, clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (out_fire) begin
      addr <= addr + ADDR_W'(4);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of the documented examples plus a
// randomized run against a transaction-level reference model. Honours
// ENC_ILLEGAL_CHECK_EN the same way the design does.
module tb_instr_encoder;

`ifdef ENC_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam int F3_OPIMM [6]  = '{0, 2, 3, 4, 6, 7};
  localparam int F3_OP    [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  localparam int F3_LOAD  [5]  = '{0, 1, 2, 4, 5};
  localparam int F3_BR    [6]  = '{0, 1, 4, 5, 6, 7};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear, in_valid, out_ready;
  logic [5:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        in_ready, out_valid, err;
  logic [31:0] instr;
  logic [9:0]  addr;
  logic        in_ready4, out_valid4, err4;
  logic [31:0] instr4;
  logic [3:0]  addr4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .addr(addr), .err(err)
  );

  // Narrow-address instance sharing the same stimulus, used for wrap checks.
  instr_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready4),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .out_valid(out_valid4),
    .out_ready(out_ready), .instr(instr4), .addr(addr4), .err(err4)
  );

  // Reference encoder: RV32I field layout built with shifts and masks.
  function automatic void model_encode(input int o, input int unsigned r1, input int unsigned r2,
                                       input int unsigned rdn, input logic [31:0] iv,
                                       output logic [31:0] w, output bit bad);
    int s;
    int unsigned f3;
    s   = $signed(iv);
    bad = 1'b0;
    w   = 32'h0000_0013;
    if (o <= 5) begin
      w = ((iv & 32'hFFF) << 20) | (r1 << 15) | (F3_OPIMM[o] << 12) | (rdn << 7) | 32'h13;
      bad = CHECK_EN && (s < -2048 || s > 2047);
    end else if (o <= 8) begin
      f3 = (o == 6) ? 1 : 5;
      w = ((o == 8) ? 32'h4000_0000 : 32'h0) | ((iv & 32'h1F) << 20) | (r1 << 15) |
          (f3 << 12) | (rdn << 7) | 32'h13;
      bad = CHECK_EN && (s < 0 || s > 31);
    end else if (o <= 18) begin
      w = ((o == 10 || o == 16) ? 32'h4000_0000 : 32'h0) | (r2 << 20) | (r1 << 15) |
          (F3_OP[o-9] << 12) | (rdn << 7) | 32'h33;
    end else if (o <= 23 || o == 30) begin
      f3 = (o == 30) ? 0 : F3_LOAD[o-19];
      w = ((iv & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdn << 7) |
          ((o == 30) ? 32'h67 : 32'h03);
      bad = CHECK_EN && (s < -2048 || s > 2047);
    end else if (o <= 26) begin
      w = (((iv >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | ((o - 24) << 12) |
          ((iv & 32'h1F) << 7) | 32'h23;
      bad = CHECK_EN && (s < -2048 || s > 2047);
    end else if (o <= 28) begin
      w = (iv & 32'hFFFF_F000) | (rdn << 7) | ((o == 27) ? 32'h37 : 32'h17);
      bad = CHECK_EN && ((iv & 32'hFFF) != 0);
    end else if (o == 29) begin
      w = (((iv >> 20) & 1) << 31) | (((iv >> 1) & 32'h3FF) << 21) | (((iv >> 11) & 1) << 20) |
          (((iv >> 12) & 32'hFF) << 12) | (rdn << 7) | 32'h6F;
      bad = CHECK_EN && ((s % 2) != 0 || s < -1048576 || s > 1048575);
    end else if (o <= 36) begin
      w = (((iv >> 12) & 1) << 31) | (((iv >> 5) & 32'h3F) << 25) | (r2 << 20) | (r1 << 15) |
          (F3_BR[o-31] << 12) | (((iv >> 1) & 32'hF) << 8) | (((iv >> 11) & 1) << 7) | 32'h63;
      bad = CHECK_EN && ((s % 2) != 0 || s < -4096 || s > 4094);
    end else begin
      bad = 1'b1;
    end
  endfunction

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 6))
      0:       v = int'($urandom_range(0, 4095)) - 2048;
      1:       v = int'($urandom_range(0, 31));
      2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3:       v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      4:       v = int'($urandom & 32'hFFFF_F000);
      default: v = int'($urandom);
    endcase
    return v;
  endfunction

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
  endtask

  task automatic set_req(input int o, input int r_d, input int r_1, input int r_2,
                         input logic [31:0] iv);
    in_valid = 1'b1; op = 6'(o); rd = 5'(r_d); rs1 = 5'(r_1); rs2 = 5'(r_2); imm = iv;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", instr); end
    if (addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_addi();
    apply_reset();
    set_req(0, 1, 2, 0, -1);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    if (instr !== 32'hFFF1_0093) begin errors++; $display("FAIL addi_instr: got %h want fff10093", instr); end
    if (addr !== 10'd0) begin errors++; $display("FAIL addi_addr: got %0d want 0", addr); end
    in_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    if (addr !== 10'd4) begin errors++; $display("FAIL addi_addr_next: got %0d want 4", addr); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    set_req(10, 3, 1, 2, 0);
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0: got %b want 1", out_valid); end
    if (instr !== 32'h4020_81B3) begin errors++; $display("FAIL b2b_sub: got %h want 402081b3", instr); end
    if (addr !== 10'd0) begin errors++; $display("FAIL b2b_addr0: got %0d want 0", addr); end
    set_req(26, 0, 2, 5, 8);
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b want 1", out_valid); end
    if (instr !== 32'h0051_2423) begin errors++; $display("FAIL b2b_sw: got %h want 00512423", instr); end
    if (addr !== 10'd4) begin errors++; $display("FAIL b2b_addr1: got %0d want 4", addr); end
    in_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    if (addr !== 10'd8) begin errors++; $display("FAIL b2b_addr2: got %0d want 8", addr); end
  endtask

  task automatic test_stall();
    apply_reset();
    set_req(31, 0, 1, 2, 8);
    out_ready = 1'b0;
    @(negedge clk);
    set_req(29, 1, 0, 0, 16);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
      if (instr !== 32'h0020_8463) begin errors++; $display("FAIL stall_instr[%0d]: got %h want 00208463", k, instr); end
      if (addr !== 10'd0) begin errors++; $display("FAIL stall_addr[%0d]: got %0d want 0", k, addr); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", in_ready); end
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL jal_valid: got %b want 1", out_valid); end
    if (instr !== 32'h0100_00EF) begin errors++; $display("FAIL jal_instr: got %h want 010000ef", instr); end
    if (addr !== 10'd4) begin errors++; $display("FAIL jal_addr: got %0d want 4", addr); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    bit bad;
    logic [31:0] exp_w [5];
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_req(0, k + 1, k, 0, 32'(k * 3));
      model_encode(0, k, 0, k + 1, 32'(k * 3), w, bad);
      exp_w[k] = w;
      @(negedge clk);
      checks += 3;
      if (out_valid4 !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d]: got %b want 1", k, out_valid4); end
      if (instr4 !== exp_w[k]) begin errors++; $display("FAIL wrap_instr[%0d]: got %h want %h", k, instr4, exp_w[k]); end
      if (addr4 !== 4'((k * 4) % 16)) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, addr4, (k * 4) % 16);
      end
    end
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks += 3;
    if (out_valid4 !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b want 0", out_valid4); end
    if (addr4 !== 4'd0) begin errors++; $display("FAIL wrap_clear_wins: got %0d want 0", addr4); end
    if (err4 !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err4); end
  endtask

  task automatic test_illegal();
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [9:0]  exp_addr;
    exp_valid = !CHECK_EN;
    exp_instr = CHECK_EN ? 32'h0 : 32'h0000_0013;
    exp_addr  = CHECK_EN ? 10'd0 : 10'd4;
    apply_reset();
    set_req(40, 7, 3, 4, 5);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    checks += 4;
    if (err !== 1'b1) begin errors++; $display("FAIL ill_err: got %b want 1", err); end
    if (out_valid !== exp_valid) begin errors++; $display("FAIL ill_valid: got %b want %b", out_valid, exp_valid); end
    if (instr !== exp_instr) begin errors++; $display("FAIL ill_instr: got %h want %h", instr, exp_instr); end
    if (addr !== 10'd0) begin errors++; $display("FAIL ill_addr: got %0d want 0", addr); end
    set_req(0, 1, 2, 0, -1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ill_next_valid: got %b want 1", out_valid); end
    if (instr !== 32'hFFF1_0093) begin errors++; $display("FAIL ill_next_instr: got %h want fff10093", instr); end
    if (addr !== exp_addr) begin errors++; $display("FAIL ill_next_addr: got %0d want %0d", addr, exp_addr); end
    if (err !== 1'b1) begin errors++; $display("FAIL ill_err_sticky: got %b want 1", err); end
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", out_valid); end
    if (addr !== 10'd0) begin errors++; $display("FAIL async_addr: got %0d want 0", addr); end
    if (err !== 1'b0) begin errors++; $display("FAIL async_err: got %b want 0", err); end
    if (instr !== 32'h0) begin errors++; $display("FAIL async_instr: got %h want 00000000", instr); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random(input int n);
    bit          m_valid, m_err, bad, hs, acc;
    logic [31:0] m_instr, w;
    int unsigned m_addr, m_addr4;
    apply_reset();
    m_valid = 1'b0; m_err = 1'b0; m_instr = '0; m_addr = 0; m_addr4 = 0;
    for (int c = 0; c < n; c++) begin
      checks += 4;
      if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, m_valid); end
      if (err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", c, err, m_err); end
      if (addr !== 10'(m_addr)) begin errors++; $display("FAIL rnd_addr@%0d: got %0d want %0d", c, addr, m_addr); end
      if (addr4 !== 4'(m_addr4)) begin errors++; $display("FAIL rnd_addr4@%0d: got %0d want %0d", c, addr4, m_addr4); end
      if (m_valid) begin
        checks++;
        if (instr !== m_instr) begin errors++; $display("FAIL rnd_instr@%0d: got %h want %h", c, instr, m_instr); end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 19) == 0);
      op        = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(37, 63)) : 6'($urandom_range(0, 36));
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      imm = rand_imm();
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, !m_valid || out_ready);
      end
      model_encode(int'(op), rs1, rs2, rd, imm, w, bad);
      hs  = m_valid && out_ready;
      acc = in_valid && (!m_valid || out_ready);
      if (clear) begin
        m_addr = 0; m_addr4 = 0;
      end else if (hs) begin
        m_addr = (m_addr + 4) % 1024; m_addr4 = (m_addr4 + 4) % 16;
      end
      if (acc && !(bad && CHECK_EN)) begin
        m_valid = 1'b1; m_instr = w;
      end else if (hs) begin
        m_valid = 1'b0;
      end
      if (acc && bad) m_err = 1'b1;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_illegal();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
